sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for buffering within one clock domain. It replaces ad-hoc dual-clock instances where both sides share a clock. Depth is generalised to any integer (not only powers of two). It adds an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.

---
 rtl/sync_fifo.sv | 83 ++++++++
 tb/tb_sync_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with any-integer depth, occupancy count, almost flags, error pulses and optional FWFT read
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             wr_acc, rd_acc;
    logic [CW-1:0]    count_next;

    // acceptance is gated by the registered flags; rejected requests change nothing
    always_comb begin
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        count_next = count + CW'(wr_acc) - CW'(rd_acc);
    end

    // storage array, cleared on reset so stale data never reappears
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_acc) begin
            mem[wr_ptr] <= in;
        end
    end

    // pointers wrap explicitly at DEPTH-1; flags come from count_next so they track count exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count        <= count_next;
            full         <= count_next == CW'(DEPTH);
            empty        <= count_next == '0;
            almost_full  <= count_next >= CW'(AF_LEVEL);
            almost_empty <= count_next <= CW'(AE_LEVEL);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out = mem[rd_ptr];
        end else begin : g_std
            // registered read data, held when no read is accepted
            always_ff @(posedge clk) begin
                if (reset) out <= '0;
                else if (rd_acc) out <= mem[rd_ptr];
            end
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for a standard-mode DEPTH=16 FIFO and a FWFT DEPTH=5 FIFO
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in0 = '0, in1 = '0;
    logic       wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
    logic [7:0] out0, out1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] count0;
    logic [2:0] count1;

    int         checks = 0, errors = 0;
    logic [7:0] q0[$], q1[$];
    logic [7:0] last0 = '0;
    bit         fresh1 = 1'b1;

    sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u0 (
        .clk(clk), .reset(reset), .in(in0), .wr_en(wr0), .rd_en(rd0), .out(out0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) u1 (
        .clk(clk), .reset(reset), .in(in1), .wr_en(wr1), .rd_en(rd1), .out(out1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(udf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic status(input bit o0, input bit u0_, input bit o1, input bit u1_);
        check("count0", 32'(count0), 32'(q0.size()));
        check("full0", 32'(full0), 32'(q0.size() == 16));
        check("empty0", 32'(empty0), 32'(q0.size() == 0));
        check("af0", 32'(af0), 32'(q0.size() >= 14));
        check("ae0", 32'(ae0), 32'(q0.size() <= 2));
        check("ovf0", 32'(ovf0), 32'(o0));
        check("udf0", 32'(udf0), 32'(u0_));
        check("out0", 32'(out0), 32'(last0));
        check("count1", 32'(count1), 32'(q1.size()));
        check("full1", 32'(full1), 32'(q1.size() == 5));
        check("empty1", 32'(empty1), 32'(q1.size() == 0));
        check("af1", 32'(af1), 32'(q1.size() >= 4));
        check("ae1", 32'(ae1), 32'(q1.size() <= 1));
        check("ovf1", 32'(ovf1), 32'(o1));
        check("udf1", 32'(udf1), 32'(u1_));
        if (q1.size() > 0) check("out1", 32'(out1), 32'(q1[0]));
        else if (fresh1) check("out1_rst", 32'(out1), 32'(0));
    endtask

    task automatic cyc(input bit w0, input bit r0, input logic [7:0] d0,
                       input bit w1, input bit r1, input logic [7:0] d1);
        bit aw0, ar0, aw1, ar1, o0, u0_, o1, u1_;
        aw0 = w0 && q0.size() < 16;
        ar0 = r0 && q0.size() > 0;
        aw1 = w1 && q1.size() < 5;
        ar1 = r1 && q1.size() > 0;
        o0  = w0 && q0.size() == 16;
        u0_ = r0 && q0.size() == 0;
        o1  = w1 && q1.size() == 5;
        u1_ = r1 && q1.size() == 0;
        wr0 = w0; rd0 = r0; in0 = d0;
        wr1 = w1; rd1 = r1; in1 = d1;
        if (ar0) last0 = q0.pop_front();
        if (aw0) q0.push_back(d0);
        if (ar1) void'(q1.pop_front());
        if (aw1) begin
            q1.push_back(d1);
            fresh1 = 1'b0;
        end
        @(posedge clk);
        #1;
        wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
        status(o0, u0_, o1, u1_);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr0 = 1'b1; rd0 = 1'b1; wr1 = 1'b1; rd1 = 1'b1;
        in0 = 8'hFF; in1 = 8'hFF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
        q0.delete();
        q1.delete();
        last0 = '0;
        fresh1 = 1'b1;
        status(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        // fill 0x00..0x0F, overflow on the 17th write, then drain and underflow
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h0);
        cyc(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 8'h0);
        check("last_read", 32'(out0), 32'h0F);
        cyc(1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 8'h0);
        // simultaneous read/write at count 3
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 8'h0);
        // read+write when empty: underflow, count 1
        cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h0);
        // fill to 16, then read+write when full: overflow, count 15
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0, 8'h0);
        cyc(1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 8'h0);
        // FWFT: word appears without rd_en, one read empties it
        do_reset();
        cyc(1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 8'hA5);
        check("fwft_a5", 32'(out1), 32'hA5);
        cyc(1'b0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h0);
        // depth-5 wrap with interleaved traffic over 23 cycles
        for (int i = 0; i < 23; i++) cyc(1'b0, 1'b0, 8'h0, (i % 3) != 2, (i % 2) == 1, 8'(i + 1));
        // random mixed traffic on both FIFOs
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        // mid-operation reset at count 7, then fresh data must come back
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1, 1'b0, 8'(8'hC0 + i));
        check("pre_rst_count", 32'(count0), 32'd7);
        do_reset();
        cyc(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C);
        cyc(1'b0, 1'b1, 8'h0, 1'b0, 1'b1, 8'h0);
        check("post_rst_data", 32'(out0), 32'h3C);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
